perf_counter_unit: RTL
======================

PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, named as follows.
- clk  input  1  sole clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
REQ-002 The module SHALL have the following event inputs.
- count_en  input  1  when 1, counters advance; when 0, all counters hold
- clear  input  1  synchronous clear of all counters and of the CPI result
- stall_in  input  1  pipeline decode stall this cycle
- retire_in  input  1  one instruction retired this cycle
- arith_in  input  1  retired instruction is arithmetic (ALU or vector ALU); qualified by retire_in
- mem_req_in  input  1  RAM read or write request level (rden or wren)
REQ-003 The module SHALL have the following outputs, each a 32-bit value zero-extended to 256 bits.
- stall_count_out  output  256  stall-cycle count
- cycles_per_instruction_q78_out  output  256  CPI in unsigned Q7.8 format, in bits [15:0]
- arith_count_out  output  256  arithmetic instruction count
- mem_access_count_out  output  256  memory access count
REQ-004 The module SHALL have no parameters; all counters are 32 bits wide and the CPI result has 8 fractional bits.

Function
REQ-005 The counters SHALL be internal 32-bit unsigned registers: cyc_cnt, instr_cnt, stall_cnt, arith_cnt and mem_cnt.
REQ-006 When count_en=1, each counter SHALL increment as follows; each saturates at 0xFFFFFFFF and never wraps.
- cyc_cnt: every cycle
- instr_cnt: when retire_in=1
- stall_cnt: when stall_in=1
- arith_cnt: when retire_in=1 and arith_in=1
- mem_cnt: on each rising edge of mem_req_in, i.e. mem_req_in=1 and a registered copy of it = 0
REQ-007 The registered copy of mem_req_in SHALL update every cycle regardless of count_en.
REQ-008 Each counter output SHALL equal its counter's registered value with zero latency from the register.
REQ-009 The CPI calculation SHALL use a three-state machine: IDLE, DIV and DONE.
REQ-010 In IDLE with instr_cnt≠0 and clear=0, the block SHALL capture a snapshot and move to DIV.
- dividend: 40-bit {cyc_cnt, 8'h00}
- divisor: instr_cnt
- iteration counter: 0
REQ-011 In IDLE with instr_cnt=0, the block SHALL stay in IDLE and hold the CPI output.
REQ-012 DIV SHALL run a restoring shift-subtract division, one quotient bit per cycle, MSB first, for exactly 40 cycles, then move to DONE.
REQ-013 In DONE, the CPI output [15:0] SHALL load the 40-bit quotient, saturated to 0xFFFF if any of quotient bits [39:16] is set; the state then returns to IDLE.
REQ-014 The CPI output SHALL update exactly 42 cycles after the snapshot edge, and it SHALL hold its value between updates.
REQ-015 The divider SHALL operate independently of count_en; counter changes during DIV SHALL NOT affect the operation in progress.
REQ-016 clear=1 SHALL have the following effects on the next edge.
- All counters go to 0, with clear taking priority over a simultaneous increment.
- The CPI output goes to 0.
- The FSM goes to IDLE, aborting any division in progress.
REQ-017 Output bits [255:32] SHALL always be 0, and CPI output bits [255:16] SHALL always be 0.

Reset
REQ-018 On reset=1, the following SHALL apply on the next edge, and reset SHALL have priority over clear and count_en.
- All counters go to 0.
- The mem_req_in history register goes to 0.
- The FSM goes to IDLE and the divider registers go to 0.
- All four outputs go to 0.
REQ-019 Assertion of reset mid-division SHALL abandon the division, and no CPI update SHALL occur from it.

Verification
REQ-020 The bench SHALL cover the following directed scenarios.
- Reset, then count_en=1 for 100 cycles with retire_in on alternate cycles (50 total), then count_en=0 and wait 90 cycles -> CPI output = 0x0200; all other outputs at reset values except arith/stall/mem as driven.
- count_en=1 for 10 cycles with retire_in on 3 of them and arith_in=1 on 2 of those, stall_in=1 on 4 cycles -> arith_count_out=2, stall_count_out=4.
- mem_req_in held high for 5 cycles, low for 1, high for 3 -> mem_access_count_out=2.
- cyc_cnt=300 and instr_cnt=1 frozen (count_en=0), wait 45 cycles -> CPI = 0xFFFF (saturated, true value 0x12C00).
- clear asserted during DIV, simultaneously with retire_in=1 -> all outputs 0 next cycle, instr_cnt=0, and no CPI update 42 cycles later while instr_cnt remains 0.
- reset asserted 20 cycles into DIV -> all outputs 0, FSM IDLE, and no stale CPI value appears afterwards.

Source files
------------

// File: rtl/perf_counter_unit.sv
// Performance counter unit: five saturating 32-bit event counters plus a
// sequential restoring divider that turns cycles/instructions into a Q7.8 CPI.
module perf_counter_unit (
  input  logic         clk,
  input  logic         reset,
  input  logic         count_en,
  input  logic         clear,
  input  logic         stall_in,
  input  logic         retire_in,
  input  logic         arith_in,
  input  logic         mem_req_in,
  output logic [255:0] stall_count_out,
  output logic [255:0] cycles_per_instruction_q78_out,
  output logic [255:0] arith_count_out,
  output logic [255:0] mem_access_count_out
);

  // Counter slots: 0 cycles, 1 instructions, 2 stalls, 3 arithmetic, 4 memory
  localparam int NumCnt   = 5;
  localparam int CycIdx   = 0;
  localparam int InstrIdx = 1;
  localparam int StallIdx = 2;
  localparam int ArithIdx = 3;
  localparam int MemIdx   = 4;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } cpiState_t;

  logic [31:0]       cntVal [NumCnt];
  logic [NumCnt-1:0] incVec;
  logic              memReqPrevReg;

  cpiState_t         stateReg;
  cpiState_t         stateNext;
  logic [39:0]       quotReg;
  logic [31:0]       remReg;
  logic [31:0]       divisorReg;
  logic [5:0]        iterReg;
  logic [15:0]       cpiReg;

  logic [32:0]       remShift;
  logic              subFits;
  logic [31:0]       remDiff;

  // Memory accesses count on the rising edge of the request level only
  assign incVec = {mem_req_in & ~memReqPrevReg, retire_in & arith_in,
                   stall_in, retire_in, 1'b1};

  // Request history follows the input every cycle, independent of count_en
  always_ff @(posedge clk) begin
    if (reset) begin
      memReqPrevReg <= 1'b0;
    end else begin
      memReqPrevReg <= mem_req_in;
    end
  end

  generate
    for (genvar gi = 0; gi < NumCnt; gi++) begin : g_cnt
      logic [31:0] cntReg;

      // Saturating event counter; clear wins over a same-cycle increment
      always_ff @(posedge clk) begin
        if (reset || clear) begin
          cntReg <= '0;
        end else if (count_en && incVec[gi] && (cntReg != 32'hFFFF_FFFF)) begin
          cntReg <= cntReg + 32'd1;
        end
      end

      assign cntVal[gi] = cntReg;
    end
  endgenerate

  // One restoring-division step: bring in the next dividend bit, try to subtract
  assign remShift = {remReg, quotReg[39]};
  assign subFits  = (remShift >= {1'b0, divisorReg});
  assign remDiff  = remShift[31:0] - divisorReg;

  // CPI state register
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next state: snapshot when instructions exist, 40 steps plus a settle cycle, then publish
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (cntVal[InstrIdx] != 32'd0) stateNext = DIV;
      DIV:     if (iterReg == 6'd40) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (clear) begin
      stateNext = IDLE;
    end
  end

  // Divider datapath and CPI result register; the snapshot isolates it from live counters
  always_ff @(posedge clk) begin
    if (reset) begin
      quotReg    <= '0;
      remReg     <= '0;
      divisorReg <= '0;
      iterReg    <= '0;
      cpiReg     <= '0;
    end else if (clear) begin
      cpiReg     <= '0;
      iterReg    <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (cntVal[InstrIdx] != 32'd0) begin
            quotReg    <= {cntVal[CycIdx], 8'h00};
            remReg     <= '0;
            divisorReg <= cntVal[InstrIdx];
            iterReg    <= '0;
          end
        end
        DIV: begin
          if (iterReg != 6'd40) begin
            remReg  <= subFits ? remDiff : remShift[31:0];
            quotReg <= {quotReg[38:0], subFits};
            iterReg <= iterReg + 6'd1;
          end
        end
        DONE: begin
          cpiReg <= (|quotReg[39:16]) ? 16'hFFFF : quotReg[15:0];
        end
        default: begin
          cpiReg <= cpiReg;
        end
      endcase
    end
  end

  assign stall_count_out                = {224'd0, cntVal[StallIdx]};
  assign arith_count_out                = {224'd0, cntVal[ArithIdx]};
  assign mem_access_count_out           = {224'd0, cntVal[MemIdx]};
  assign cycles_per_instruction_q78_out = {240'd0, cpiReg};

endmodule
